// File: rtl/mcu_spi_pkg.sv
// Shared constants and types for the MCU SPI slave endpoint.
package mcu_spi_pkg;

  localparam logic [7:0] TGT_SYS     = 8'd1;
  localparam logic [7:0] TGT_HID     = 8'd2;
  localparam logic [7:0] TGT_OSD     = 8'd3;
  localparam logic [7:0] SYNC_MARKER = 8'hA5;
  localparam logic [7:0] NONE_RESP   = 8'hFF;

  typedef enum logic [1:0] {IDLE, TARGET, PAYLOAD} state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_SYS, SEL_HID, SEL_OSD} target_e;

  function automatic target_e decode_target(input logic [7:0] id);
    case (id)
      TGT_SYS: return SEL_SYS;
      TGT_HID: return SEL_HID;
      TGT_OSD: return SEL_OSD;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with registered
// single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // The chain keeps tracking the pin through reset so that a level held
  // across reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave for the MCU link: first byte selects a target, following
// bytes are strobed to it while the target's response is shifted out on MISO.
module mcu_spi_slave
  import mcu_spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       mcu_start,
  output logic [7:0] mcu_data,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din
);

  logic sck_rise, sck_fall, csn_rise, csn_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .din(spi_sck), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
    .clk(clk), .reset(reset), .din(spi_csn), .rise(csn_rise), .fall(csn_fall)
  );

  // One stage longer than the sck chain to line up with its registered pulse.
  logic [SYNC_STAGES:0] mosi_q, mosi_d;
  logic                 mosi_bit;

  assign mosi_d   = {mosi_q[SYNC_STAGES-1:0], spi_mosi};
  assign mosi_bit = mosi_q[SYNC_STAGES];

  always_ff @(posedge clk) begin
    mosi_q <= mosi_d;
  end

  function automatic logic [7:0] resp_byte(input target_e sel, input logic [7:0] sys_din,
                                           input logic [7:0] hid_din, input logic [7:0] osd_din);
    case (sel)
      SEL_SYS: return sys_din;
      SEL_HID: return hid_din;
      SEL_OSD: return osd_din;
      default: return NONE_RESP;
    endcase
  endfunction

  state_e     state_q, state_d;
  target_e    sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic       load_q, load_d;
  logic       sys_stb_q, sys_stb_d;
  logic       hid_stb_q, hid_stb_d;
  logic       osd_stb_q, osd_stb_d;
  logic       miso_q, miso_d;
  logic [7:0] byte_now;

  assign byte_now = {rx_q[6:0], mosi_bit};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    data_d    = data_q;
    start_d   = 1'b0;
    load_d    = 1'b0;
    sys_stb_d = 1'b0;
    hid_stb_d = 1'b0;
    osd_stb_d = 1'b0;

    if (csn_rise) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      sel_d   = SEL_NONE;
    end else if (csn_fall && state_q == IDLE) begin
      state_d = TARGET;
      start_d = 1'b1;
      cnt_d   = 3'd0;
      tx_d    = SYNC_MARKER;
      sel_d   = SEL_NONE;
    end else if (state_q != IDLE) begin
      // Response is sampled in the cycle after the byte completes, which is
      // the strobe cycle for payload bytes.
      if (load_q) begin
        tx_d = resp_byte(sel_q, mcu_sys_din, mcu_hid_din, mcu_osd_din);
      end
      // Counter at zero means the byte boundary: keep the freshly loaded MSB.
      if (sck_fall && cnt_q != 3'd0) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (sck_rise) begin
        rx_d  = byte_now;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          load_d = 1'b1;
          if (state_q == TARGET) begin
            sel_d   = decode_target(byte_now);
            state_d = PAYLOAD;
          end else begin
            data_d    = byte_now;
            sys_stb_d = (sel_q == SEL_SYS);
            hid_stb_d = (sel_q == SEL_HID);
            osd_stb_d = (sel_q == SEL_OSD);
          end
        end
      end
    end

    miso_d = (state_d == IDLE) ? IDLE_MISO : tx_d[7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= SEL_NONE;
      cnt_q     <= 3'd0;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      load_q    <= 1'b0;
      sys_stb_q <= 1'b0;
      hid_stb_q <= 1'b0;
      osd_stb_q <= 1'b0;
      miso_q    <= IDLE_MISO;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      start_q   <= start_d;
      load_q    <= load_d;
      sys_stb_q <= sys_stb_d;
      hid_stb_q <= hid_stb_d;
      osd_stb_q <= osd_stb_d;
      miso_q    <= miso_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    tx_q <= tx_d;
  end

  assign spi_miso       = miso_q;
  assign mcu_start      = start_q;
  assign mcu_data       = data_q;
  assign mcu_sys_strobe = sys_stb_q;
  assign mcu_hid_strobe = hid_stb_q;
  assign mcu_osd_strobe = osd_stb_q;

endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI slave endpoint for the board MCU link. Deserializes MCU SPI traffic into byte-wide start/strobe/data pulses in the core clock domain and serializes response bytes back on MISO.
- Produces the mcu_start / mcu_osd_strobe / mcu_data stream consumed by the video/OSD path.
- Also serves the system-config and HID targets.
- Sits at top level between the MCU pins and all MCU-facing consumers.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on spi_sck, spi_csn and spi_mosi before edge detection (range 2..3).
- IDLE_MISO, 1'b0: MISO level while spi_csn is high.

Ports:
- clk  in  1  core/pixel clock; every register is in this domain.
- reset  in  1  synchronous, active-high.
- spi_sck  in  1  MCU SPI clock, asynchronous, CPOL=0.
- spi_csn  in  1  MCU chip select, asynchronous, active-low.
- spi_mosi  in  1  MCU data in, asynchronous.
- spi_miso  out  1  data to MCU, registered.
- mcu_start  out  1  one-cycle pulse at start of transaction.
- mcu_data  out  8  last received payload byte.
- mcu_sys_strobe  out  1  payload byte valid for system target.
- mcu_hid_strobe  out  1  payload byte valid for HID target.
- mcu_osd_strobe  out  1  payload byte valid for OSD target.
- mcu_sys_din  in  8  response byte from system target.
- mcu_hid_din  in  8  response byte from HID target.
- mcu_osd_din  in  8  response byte from OSD target.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. On reset, all strobes and mcu_start = 0, mcu_data = 8'h00, spi_miso = IDLE_MISO, state = IDLE, bit counter = 0, target = NONE.
- SPI mode 0, MSB first. MOSI is sampled at the synchronized SCK rising edge; the MISO shift happens at the synchronized SCK falling edge.
- Timing constraint: each SCK half-period must be at least SYNC_STAGES+2 clk cycles. Behaviour is undefined if this is violated.
- States:
  - IDLE: csn high.
  - TARGET: first byte of a transaction.
  - PAYLOAD: all following bytes.
- IDLE->TARGET on a synchronized csn falling edge. mcu_start = 1 for exactly that one cycle. Bit counter cleared. TX shift register loaded with 8'hA5 (sync marker).
- Byte completion: the 3-bit counter increments on each rising edge. When the 8th rising edge is detected, the assembled byte is complete.
  - In TARGET: latch the target ID (1=SYS, 2=HID, 3=OSD, other=NONE) and go to PAYLOAD. No strobe and no mcu_data update.
  - In PAYLOAD: mcu_data <= byte, and the strobe of the selected target = 1 one cycle after the 8th rising edge is detected. It stays high for exactly one cycle. mcu_data holds until the next payload byte.
- Response load: in the strobe cycle (and the equivalent cycle for the TARGET byte), the TX register loads the selected target's din, sampled in that same cycle. For target NONE it loads 8'hFF.
- spi_miso = tx[7] while csn is low. A falling edge shifts tx left only when the bit counter != 0, so the falling edge after the 8th bit does not disturb the freshly loaded byte.
- csn rising edge (any state): go to IDLE. A partial byte is discarded with no strobe. spi_miso = IDLE_MISO on the next cycle.
- csn falling and rising detected in the same cycle (glitch shorter than the sync window): ignored, stay in IDLE.
- reset mid-transaction: immediate return to the reset values. The remainder of that transaction is ignored until the next csn falling edge.
- Target NONE: payload bytes are still counted and mcu_data is still updated, but no strobe fires.
- At most one strobe is high in any cycle.

Decomposition:
- Package mcu_spi_pkg holds:
  - target ID constants TGT_SYS=8'd1, TGT_HID=8'd2, TGT_OSD=8'd3;
  - SYNC_MARKER=8'hA5 and NONE_RESP=8'hFF;
  - the state enum {IDLE, TARGET, PAYLOAD}.
- Sub-module spi_sync_edge: a SYNC_STAGES synchronizer plus registered rise/fall pulse outputs. Instantiate it for sck and csn. mosi goes through a plain synchronizer delay-matched to sck.

Test Plan:
- Reset sequence: assert reset for 3 clk cycles with csn high -> all strobes 0, mcu_data=8'h00, spi_miso=0, mcu_start never pulses.
- csn low, send 8'h03, then 8'h12 and 8'h34 (SCK half-period 6 clk) -> mcu_start pulses once; mcu_osd_strobe pulses twice with mcu_data=8'h12 then 8'h34; sys/hid strobes stay 0.
- Same transfer with mcu_osd_din=8'hC3 held -> MISO bits read on rising SCK: byte0=8'hA5, byte1=8'hC3, byte2=8'hC3.
- Target 8'h07 followed by 8'h55 -> no strobe fires, mcu_data=8'h55, MISO second byte=8'hFF.
- Target 8'h01, then csn raised after 5 bits of 8'hFF -> no mcu_sys_strobe, mcu_data unchanged, spi_miso returns to 0 within SYNC_STAGES+2 cycles. A new transaction starting 8'h02, 8'h9A then yields a single mcu_hid_strobe with 8'h9A.
- reset asserted mid-payload byte, then released while csn is still low -> no strobe until the next csn falling edge; the next transaction decodes normally.
